wb_host_initiator: RTL and testbench

- Wishbone classic-cycle initiator that drives the user-area Wishbone responder (design-select, counter and custom-settings registers) from a simple command/response stream.
- Used by on-chip test sequencers and the bring-up harness to issue register reads and writes without the management core.
- Queues commands in a small FIFO, runs one bus cycle at a time with an ack timeout, and returns responses in command order.

---
 rtl/wb_host_initiator.sv | 188 ++++++++++++++++++
 tb/tb_wb_host_initiator.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_initiator.sv
// wb_host_initiator
//   Wishbone classic-cycle initiator fed by a command/response stream.
//   Commands are queued in a pointer-based FIFO and executed one bus cycle
//   at a time with an ack timeout; responses leave in command order.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, synchronous active-low reset
//   cmd_valid/ready/we/adr/dat/sel  command stream (push on valid && ready)
//   rsp_valid/ready/dat/err/we      response stream (pop on valid && ready)
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o  Wishbone initiator outputs
//   wbm_dat_i, wbm_ack_i          Wishbone responder inputs
//   busy                          FIFO non-empty or FSM not idle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a queued command; pops the FIFO head on entry to BUS
// BUS   | cyc/stb high, waiting for ack or timeout
// RSP   | response presented, waiting for rsp_ready
// GAP   | enforced bus-idle time before the next command
module wb_host_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int IDLE_GAP   = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_we,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(IDLE_GAP + 1);

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        BUS  = 2'd2,
        RSP  = 2'd3
    } state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rdy_en_q;
    logic          empty, full, push, pop;

    state_t        state_q, state_d;
    cmd_t          hold_q, hold_d;
    logic [7:0]    wait_q, wait_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // rdy_en_q keeps cmd_ready low at and during reset, high from the first
    // edge after release.
    assign cmd_ready = rdy_en_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && !empty;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rdy_en_q  <= 1'b0;
            state_q   <= IDLE;
            hold_q    <= '0;
            wait_q    <= '0;
            gap_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rdy_en_q  <= 1'b1;
            state_q   <= state_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            gap_q     <= gap_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    hold_d  = mem_q[rd_ptr_q[AW-1:0]];
                    wait_d  = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack is only honoured here; ack wins over a coincident timeout.
                if (wbm_ack_i) begin
                    rsp_dat_d = hold_q.we ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = RSP;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    rsp_dat_d = 32'hFFFF_FFFF;
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RSP: begin
                // The RSP exit edge counts as the first gap cycle.
                if (rsp_ready) begin
                    if (IDLE_GAP > 1) begin
                        gap_d   = GW'(1);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q >= GW'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_we_o  = hold_q.we;
    assign wbm_adr_o = hold_q.adr;
    assign wbm_dat_o = hold_q.dat;
    assign wbm_sel_o = hold_q.sel;

    assign rsp_valid = (state_q == RSP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_we    = hold_q.we;

    assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Testbench for wb_host_initiator: behavioural responder with programmable
// ack position/length, bus monitor and an in-order response scoreboard.
module tb_wb_host_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_we;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        we;
    } exp_t;
    exp_t sb[$];

    // responder configuration
    int   ack_at   = 3;
    int   ack_hold = 1;
    int   stb_cnt  = 0;
    int   ack_left = 0;
    logic resp_ack = 1'b0;
    logic late_ack = 1'b0;

    // monitor state
    int   run_len = 0;
    int   gap_len = 0;
    int   min_gap = 1000;
    bit   have_run = 0;
    int   unstable = 0;
    int   stb_neq = 0;
    int   rsp_cnt = 0;
    int   rsp_seen = 0;
    logic [31:0] run_adr, run_dat;
    logic [3:0]  run_sel;
    logic        run_we;
    int   cyc_lens[$];
    logic run_wes[$];

    always #5 clk = ~clk;

    wb_host_initiator dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .rsp_we   (rsp_we),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy)
    );

    function automatic logic [31:0] rdata_fn(input logic [31:0] a);
        if (a == 32'h3010_0008) return 32'h1234_5678;
        return a ^ 32'hDEAD_0000;
    endfunction

    assign wbm_ack_i = resp_ack | late_ack;
    assign wbm_dat_i = rdata_fn(wbm_adr_o);

    // Responder: ack on the ack_at-th stb cycle, held for ack_hold cycles
    // (the tail may spill past the end of the bus cycle).
    always @(negedge clk) begin
        if (wbm_cyc_o === 1'b1) begin
            stb_cnt = stb_cnt + 1;
            if (ack_at != 0 && stb_cnt == ack_at) begin
                resp_ack = 1'b1;
                ack_left = ack_hold - 1;
            end else if (ack_left > 0) begin
                resp_ack = 1'b1;
                ack_left = ack_left - 1;
            end else begin
                resp_ack = 1'b0;
            end
        end else begin
            stb_cnt = 0;
            if (ack_left > 0) begin
                resp_ack = 1'b1;
                ack_left = ack_left - 1;
            end else begin
                resp_ack = 1'b0;
            end
        end
    end

    // Bus monitor and response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (wbm_cyc_o !== wbm_stb_o) stb_neq = stb_neq + 1;
        if (wbm_cyc_o === 1'b1) begin
            if (run_len == 0) begin
                if (have_run && gap_len < min_gap) min_gap = gap_len;
                run_adr = wbm_adr_o;
                run_dat = wbm_dat_o;
                run_sel = wbm_sel_o;
                run_we  = wbm_we_o;
            end else if (wbm_adr_o !== run_adr || wbm_dat_o !== run_dat ||
                         wbm_sel_o !== run_sel || wbm_we_o !== run_we) begin
                unstable = unstable + 1;
            end
            run_len = run_len + 1;
        end else begin
            if (run_len != 0) begin
                cyc_lens.push_back(run_len);
                run_wes.push_back(run_we);
                have_run = 1;
                gap_len  = 0;
            end
            run_len = 0;
            gap_len = gap_len + 1;
        end

        if (rsp_valid === 1'b1) rsp_seen = rsp_seen + 1;
        if (rsp_valid === 1'b1 && rsp_ready) begin
            rsp_cnt = rsp_cnt + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL rsp_unexpected: got dat=%h err=%b, required no response", rsp_dat, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_dat !== e.dat) begin
                    errors = errors + 1;
                    $display("FAIL rsp_dat: got %h, required %h", rsp_dat, e.dat);
                end
                checks = checks + 1;
                if (rsp_err !== e.err) begin
                    errors = errors + 1;
                    $display("FAIL rsp_err: got %b, required %b", rsp_err, e.err);
                end
                checks = checks + 1;
                if (rsp_we !== e.we) begin
                    errors = errors + 1;
                    $display("FAIL rsp_we: got %b, required %b", rsp_we, e.we);
                end
            end
        end
    end

    task automatic clear_mon();
        cyc_lens.delete();
        run_wes.delete();
        min_gap  = 1000;
        have_run = 0;
        unstable = 0;
        stb_neq  = 0;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit exp_to, input bit record);
        bit   ok = 0;
        exp_t e;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1; break; end
        end
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL push_accept: adr=%h not accepted within 200 cycles, required accept", adr);
        end else if (record) begin
            e.dat = exp_to ? 32'hFFFF_FFFF : (we ? 32'h0 : rdata_fn(adr));
            e.err = exp_to;
            e.we  = we;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && sb.size() == 0 && wbm_cyc_o === 1'b0) begin ok = 1; break; end
        end
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s_idle: busy=%b pending=%0d after 500 cycles, required idle", name, busy, sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks = checks + 4;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b/%b, required 0/0", wbm_cyc_o, wbm_stb_o); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        if (busy !== 1'b0 || wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_busy_adr: got %b/%h, required 0/0", busy, wbm_adr_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks = checks + 1;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_write();
        clear_mon();
        ack_at = 3; ack_hold = 1;
        push_cmd(1'b1, 32'h3010_0004, 32'h0000_0015, 4'hF, 1'b0, 1'b1);
        wait_idle("write");
        checks = checks + 4;
        if (cyc_lens.size() != 1) begin errors++; $display("FAIL write_runs: got %0d bus cycles, required 1", cyc_lens.size()); end
        else begin
            if (cyc_lens[0] != 3) begin errors++; $display("FAIL write_cyc_len: got %0d, required 3", cyc_lens[0]); end
            if (run_wes[0] !== 1'b1) begin errors++; $display("FAIL write_we: got %b, required 1", run_wes[0]); end
        end
        if (unstable != 0 || stb_neq != 0) begin errors++; $display("FAIL write_stable: got %0d/%0d glitches, required 0", unstable, stb_neq); end
    endtask

    task automatic test_read();
        clear_mon();
        ack_at = 3; ack_hold = 1;
        push_cmd(1'b0, 32'h3010_0008, 32'h0, 4'hF, 1'b0, 1'b1);
        wait_idle("read");
        checks = checks + 2;
        if (cyc_lens.size() != 1 || cyc_lens[0] != 3) begin errors++; $display("FAIL read_cyc_len: got %0d runs, required one run of 3", cyc_lens.size()); end
        else if (run_wes[0] !== 1'b0) begin errors++; $display("FAIL read_we: got %b, required 0", run_wes[0]); end
        if (unstable != 0) begin errors++; $display("FAIL read_stable: got %0d, required 0", unstable); end
    endtask

    task automatic test_timeout();
        int  c0;
        bit  seen = 0;
        clear_mon();
        ack_at = 0; ack_hold = 1;
        c0 = rsp_cnt;
        push_cmd(1'b0, 32'h3010_000C, 32'h0, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin seen = 1; break; end
        end
        checks = checks + 1;
        if (!seen) begin errors++; $display("FAIL timeout_rsp: no response within 100 cycles, required one"); end
        // handshake edge follows; pulse a late ack while the FSM sits in GAP
        @(posedge clk); #1;
        late_ack = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
        wait_idle("timeout");
        repeat (5) @(negedge clk);
        checks = checks + 2;
        if (cyc_lens.size() != 1 || cyc_lens[0] != 16) begin errors++; $display("FAIL timeout_stb_len: got %0d runs (first %0d), required one run of 16", cyc_lens.size(), cyc_lens.size() ? cyc_lens[0] : 0); end
        if (rsp_cnt - c0 != 1) begin errors++; $display("FAIL timeout_rsp_count: got %0d, required 1", rsp_cnt - c0); end
    endtask

    task automatic test_capacity();
        int  c0;
        bit  ok = 0;
        exp_t e;
        clear_mon();
        ack_at = 2; ack_hold = 1;
        c0 = rsp_cnt;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(1'b0, 32'h3010_0010 + 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3010_0024; cmd_dat = '0; cmd_sel = 4'hF;
        repeat (6) @(negedge clk);
        checks = checks + 2;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cap_full: cmd_ready got %b, required 0", cmd_ready); end
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cap_rsp_hold: rsp_valid got %b, required 1", rsp_valid); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1; break; end
        end
        checks = checks + 1;
        if (!ok) begin errors++; $display("FAIL cap_sixth_accept: not accepted, required accept"); end
        else begin
            e.dat = rdata_fn(32'h3010_0024); e.err = 1'b0; e.we = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle("capacity");
        checks = checks + 2;
        if (rsp_cnt - c0 != 6 || cyc_lens.size() != 6) begin errors++; $display("FAIL cap_count: got %0d rsp %0d runs, required 6/6", rsp_cnt - c0, cyc_lens.size()); end
        if (min_gap < 2) begin errors++; $display("FAIL cap_gap: min cyc-low got %0d, required >=2", min_gap); end
    endtask

    task automatic test_stale_ack();
        int c0;
        clear_mon();
        ack_at = 2; ack_hold = 2;
        c0 = rsp_cnt;
        push_cmd(1'b1, 32'h3010_0030, 32'hA5A5_0001, 4'h3, 1'b0, 1'b1);
        push_cmd(1'b0, 32'h3010_0034, 32'h0, 4'hF, 1'b0, 1'b1);
        wait_idle("stale");
        checks = checks + 3;
        if (rsp_cnt - c0 != 2) begin errors++; $display("FAIL stale_rsp_count: got %0d, required 2", rsp_cnt - c0); end
        if (cyc_lens.size() != 2 || cyc_lens[0] != 2 || cyc_lens[1] != 2) begin errors++; $display("FAIL stale_cyc_lens: got %0d runs, required two runs of 2", cyc_lens.size()); end
        if (min_gap < 2) begin errors++; $display("FAIL stale_gap: got %0d, required >=2", min_gap); end
        ack_hold = 1;
    endtask

    task automatic test_reset_mid();
        int  s0;
        bit  up = 0;
        clear_mon();
        ack_at = 0; ack_hold = 1;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b0, 32'h3010_0040 + 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        up = (wbm_cyc_o === 1'b1);
        checks = checks + 1;
        if (!up) begin errors++; $display("FAIL rstmid_in_bus: cyc got %b, required 1", wbm_cyc_o); end
        s0 = rsp_seen;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks = checks + 2;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got %b/%b, required 0/0", wbm_cyc_o, wbm_stb_o); end
        if (busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_busy_ready: got %b/%b, required 0/0", busy, cmd_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks = checks + 1;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %b, required 1", cmd_ready); end
        repeat (30) @(negedge clk);
        checks = checks + 2;
        if (rsp_seen != s0) begin errors++; $display("FAIL rstmid_no_rsp: rsp_valid seen %0d cycles, required 0", rsp_seen - s0); end
        if (busy !== 1'b0 || cyc_lens.size() != 1) begin errors++; $display("FAIL rstmid_flushed: busy=%b runs=%0d, required 0/1", busy, cyc_lens.size()); end
        // queue must be empty: one fresh read gives exactly one response
        ack_at = 2;
        s0 = rsp_cnt;
        push_cmd(1'b0, 32'h3010_0050, 32'h0, 4'hF, 1'b0, 1'b1);
        wait_idle("rstmid_after");
        checks = checks + 1;
        if (rsp_cnt - s0 != 1) begin errors++; $display("FAIL rstmid_after_count: got %0d, required 1", rsp_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_capacity();
        test_stale_ack();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
